// File: rtl/rca_adder_pkg.sv
// Shared configuration for the ripple-carry adder slice.
package rca_adder_pkg;

    localparam int DEFAULT_N = 4;

endpackage

// File: rtl/rca_adder_if.sv
// Operand/result bundle for rca_adder: the producer drives A/B/Cin, the adder returns SUM/Cout.
interface rca_adder_if #(
    parameter int N = rca_adder_pkg::DEFAULT_N
);

    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic [N-1:0] SUM;
    logic         Cout;

    modport master (output A, output B, output Cin, input SUM, input Cout);
    modport slave  (input A, input B, input Cin, output SUM, output Cout);

endinterface

// File: rtl/rca_adder_full_adder.sv
// One-bit full adder cell used as the ripple stage of rca_adder.
module rca_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rca_adder.sv
// N-bit ripple-carry adder with a single registered output stage ({Cout,SUM} = A + B + Cin).
module rca_adder
    import rca_adder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic        clk,
    input  logic        rst_n,
    rca_adder_if.slave  bus
);

    logic [N:0]   c;
    logic [N-1:0] s;

    assign c[0] = bus.Cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        rca_adder_full_adder u_fa (
            .a  (bus.A[i]),
            .b  (bus.B[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.SUM  <= '0;
            bus.Cout <= 1'b0;
        end else begin
            bus.SUM  <= s;
            bus.Cout <= c[N];
        end
    end

`ifndef synthesis
    // Sampled output at edge k holds the result registered at edge k-1.
    a_sum_matches : assert property (@(posedge clk)
        (rst_n && $past(rst_n)) |->
            ({bus.Cout, bus.SUM} == $past({1'b0, bus.A} + {1'b0, bus.B} + (N+1)'(bus.Cin))));

    a_reset_zero : assert property (@(posedge clk)
        !rst_n |-> ({bus.Cout, bus.SUM} == '0));
`endif

endmodule

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder (N = 4): directed table, reset sequences, exhaustive and random streams.
module tb_rca_adder;

    localparam int N = 4;

    typedef struct {
        string        name;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] sum;
        logic         cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rca_adder_if #(.N(N)) bus ();

    rca_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [N:0] pending[$];
    string      pending_name[$];

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {Cout,SUM}=0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned integer addition, kept to N+1 bits.
    function automatic logic [N:0] model(input int a, input int b, input int cin);
        int total;
        total = a + b + cin;
        return (N+1)'(total % (1 << (N + 1)));
    endfunction

    function automatic logic [N:0] result();
        return {bus.Cout, bus.SUM};
    endfunction

    // Called at a negedge: checks the result of the previous operand set, then drives a new one.
    task automatic stream_step(input string name, input int a, input int b, input int cin);
        if (pending.size() > 0)
            check(pending_name.pop_front(), result(), pending.pop_front());
        bus.A   = N'(a);
        bus.B   = N'(b);
        bus.Cin = 1'(cin);
        pending.push_back(model(a, b, cin));
        pending_name.push_back(name);
    endtask

    task automatic stream_flush();
        @(negedge clk);
        while (pending.size() > 0)
            check(pending_name.pop_front(), result(), pending.pop_front());
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"no_carry",    4'd5,  4'd3,  1'b0, 4'd8,  1'b0};
        vecs[1] = '{"full_ripple", 4'd7,  4'd8,  1'b1, 4'd0,  1'b1};
        vecs[2] = '{"max",         4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[3] = '{"zero",        4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vecs[4] = '{"wrap",        4'd9,  4'd9,  1'b0, 4'd2,  1'b1};
        vecs[5] = '{"top_no_cout", 4'd10, 4'd5,  1'b0, 4'd15, 1'b0};

        rst_n   = 1'b0;
        bus.A   = 4'd9;
        bus.B   = 4'd6;
        bus.Cin = 1'b1;

        #1 check("reset_initial", result(), '0);
        repeat (2) @(negedge clk);
        check("reset_held", result(), '0);

        // Release at a negedge; first posedge registers the operands driven here.
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            bus.A   = vecs[i].a;
            bus.B   = vecs[i].b;
            bus.Cin = vecs[i].cin;
            @(negedge clk);
            check(vecs[i].name, result(), {vecs[i].cout, vecs[i].sum});
        end

        // Reset asserted between edges must clear outputs immediately.
        bus.A   = 4'd11;
        bus.B   = 4'd12;
        bus.Cin = 1'b0;
        @(posedge clk);
        #2 check("pre_reset_value", result(), 5'd23);
        #1 rst_n = 1'b0;
        #1 check("reset_async", result(), '0);
        @(posedge clk);
        #1 check("reset_hold_edge", result(), '0);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.A   = 4'd2;
        bus.B   = 4'd2;
        bus.Cin = 1'b0;
        @(negedge clk);
        check("post_reset_first", result(), 5'd4);

        for (int idx = 0; idx < 512; idx++) begin
            @(negedge clk);
            stream_step("exhaustive", (idx >> 5) & 15, (idx >> 1) & 15, idx & 1);
        end
        stream_flush();

        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            stream_step("random", int'($urandom_range(15)), int'($urandom_range(15)),
                        int'($urandom_range(1)));
        end
        stream_flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
